// File: rtl/cnt_mode_pkg.sv
// cnt_mode_pkg: shared state encoding, mode encodings and debounce default for cnt_mode_ctrl
package cnt_mode_pkg;

   localparam int DEB_CYCLES_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      UP    = 2'b01,
      DOWN  = 2'b10,
      PAUSE = 2'b11
   } state_t;

   // {cnt_in1,cnt_in0} as seen by the up/down counter
   localparam logic [1:0] MODE_IDLE  = 2'b00;
   localparam logic [1:0] MODE_UP    = 2'b10;
   localparam logic [1:0] MODE_DOWN  = 2'b01;
   localparam logic [1:0] MODE_PAUSE = 2'b11;

   function automatic logic [1:0] mode_of(input state_t s);
      return (s == UP) ? MODE_UP : (s == DOWN) ? MODE_DOWN : (s == PAUSE) ? MODE_PAUSE : MODE_IDLE;
   endfunction

endpackage

// File: rtl/cnt_debounce.sv
// cnt_debounce: 2-flop synchronizer, level debouncer and rising-edge event pulse for one button
module cnt_debounce #(
   parameter int DEB_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_evt
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          r_s1, r_s2, r_lvl, r_prv;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_lvl <= 1'b0;
         r_prv <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1  <= i_btn;
         r_s2  <= r_s1;
         r_prv <= r_lvl;
         // flip on the DEB_CYCLES-th consecutive disagreeing sample
         if (r_s2 == r_lvl)
            r_cnt <= '0;
         else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
            r_lvl <= r_s2;
            r_cnt <= '0;
         end else
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_evt = r_lvl & ~r_prv;

endmodule

// File: rtl/cnt_mode_ctrl.sv
// cnt_mode_ctrl: debounced button FSM selecting the up/down counter mode (idle/up/down/pause)
module cnt_mode_ctrl
   import cnt_mode_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter bit AUTO_STOP  = 1'b0
) (
   input  logic       cnt_clk,
   input  logic       cnt_rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_stop,
   input  logic [3:0] count_in,
   output logic       cnt_in0,
   output logic       cnt_in1,
   output logic [1:0] mode_state
);

   logic       w_up, w_dn, w_st, w_lim;
   state_t     r_state, w_next;
   logic [1:0] r_mode;

   cnt_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up   (.clk(cnt_clk), .rst(cnt_rst), .i_btn(btn_up),   .o_evt(w_up));
   cnt_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_down (.clk(cnt_clk), .rst(cnt_rst), .i_btn(btn_down), .o_evt(w_dn));
   cnt_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_stop (.clk(cnt_clk), .rst(cnt_rst), .i_btn(btn_stop), .o_evt(w_st));

   assign w_lim = AUTO_STOP && ((r_state == UP && count_in == 4'd15) || (r_state == DOWN && count_in == 4'd0));

   // button events take priority over the auto-stop limit
   always_comb
      w_next = w_st ? ((r_state == UP || r_state == DOWN) ? PAUSE : IDLE) :
               w_up ? UP : w_dn ? DOWN : w_lim ? PAUSE : r_state;

   always_ff @(posedge cnt_clk) begin
      if (cnt_rst) begin
         r_state <= IDLE;
         r_mode  <= MODE_IDLE;
      end else begin
         r_state <= w_next;
         r_mode  <= mode_of(w_next);
      end
   end

   assign {cnt_in1, cnt_in0} = r_mode;
   assign mode_state         = r_state;

endmodule

// File: tb/tb_cnt_mode_ctrl.sv
// tb_cnt_mode_ctrl: random + directed stimulus on two instances (AUTO_STOP 0 and 1) against a behavioural model
module tb_cnt_mode_ctrl;

   localparam int DEB = 8;

   logic       clk = 1'b0, rst = 1'b1, bu = 1'b0, bd = 1'b0, bs = 1'b0;
   logic [3:0] cin = 4'd5;
   logic       a0, a1, b0, b1;
   logic [1:0] ms0, ms1;

   cnt_mode_ctrl #(.DEB_CYCLES(DEB), .AUTO_STOP(1'b0)) u0 (
      .cnt_clk(clk), .cnt_rst(rst), .btn_up(bu), .btn_down(bd), .btn_stop(bs),
      .count_in(cin), .cnt_in0(a0), .cnt_in1(a1), .mode_state(ms0));
   cnt_mode_ctrl #(.DEB_CYCLES(DEB), .AUTO_STOP(1'b1)) u1 (
      .cnt_clk(clk), .cnt_rst(rst), .btn_up(bu), .btn_down(bd), .btn_stop(bs),
      .count_in(cin), .cnt_in0(b0), .cnt_in1(b1), .mode_state(ms1));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   bit started = 0;

   // model: synchronizer delay line, run length of disagreeing samples, accepted level
   bit [2:0] s1 = 0, s2 = 0, lvl = 0, prv = 0;
   int       run [3] = '{0, 0, 0};
   int       st  [2] = '{0, 0};
   int       outv[4] = '{0, 2, 1, 3};   // state -> {cnt_in1,cnt_in0}

   function automatic int nxt(int s, bit [2:0] ev, bit auto_en, logic [3:0] c);
      if (ev[2]) return (s == 1 || s == 2) ? 3 : 0;
      if (ev[0]) return 1;
      if (ev[1]) return 2;
      if (auto_en && ((s == 1 && c == 4'd15) || (s == 2 && c == 4'd0))) return 3;
      return s;
   endfunction

   always @(posedge clk) begin
      bit [2:0] raw, ev;
      raw = {bs, bd, bu};
      started = 1;
      if (rst) begin
         s1 = 0; s2 = 0; lvl = 0; prv = 0;
         run = '{0, 0, 0};
         st  = '{0, 0};
      end else begin
         ev = lvl & ~prv;
         st[0] = nxt(st[0], ev, 1'b0, cin);
         st[1] = nxt(st[1], ev, 1'b1, cin);
         prv = lvl;
         for (int b = 0; b < 3; b++) begin
            if (s2[b] != lvl[b]) begin
               run[b]++;
               if (run[b] == DEB) begin
                  lvl[b] = s2[b];
                  run[b] = 0;
               end
            end else run[b] = 0;
         end
         s2 = s1;
         s1 = raw;
      end
   end

   task automatic chk(input string n, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("state_a0", int'(ms0), st[0]);
         chk("mode_a0", int'({a1, a0}), outv[st[0]]);
         chk("state_a1", int'(ms1), st[1]);
         chk("mode_a1", int'({b1, b0}), outv[st[1]]);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_up(input int n);
      bu = 1; cyc(n); bu = 0; cyc(15);
   endtask
   task automatic press_dn(input int n);
      bd = 1; cyc(n); bd = 0; cyc(15);
   endtask
   task automatic press_st(input int n);
      bs = 1; cyc(n); bs = 0; cyc(15);
   endtask

   initial begin
      bit [2:0] btn;
      cyc(3);
      rst = 0;
      cyc(20);
      chk("idle_after_reset", int'(ms0), 0);
      chk("idle_mode_after_reset", int'({a1, a0}), 0);
      // up press: output changes on the 11th edge after first high sample
      bu = 1;
      cyc(10);
      chk("up_edge10_still_idle", int'(ms0), 0);
      cyc(1);
      chk("up_edge11_state", int'(ms0), 1);
      chk("up_edge11_mode", int'({a1, a0}), 2);
      cyc(9);
      bu = 0;
      cyc(15);
      // short down glitches are ignored
      repeat (3) begin
         bd = 1; cyc(7); bd = 0; cyc(10);
      end
      chk("glitch_ignored", int'(ms0), 1);
      press_dn(12);
      chk("down_state", int'(ms0), 2);
      chk("down_mode", int'({a1, a0}), 1);
      press_st(12);
      chk("stop_in_down_pause", int'({a1, a0}), 3);
      press_st(12);
      chk("stop_in_pause_idle", int'({a1, a0}), 0);
      press_st(12);
      chk("stop_in_idle_stays", int'(ms0), 0);
      // simultaneous presses
      bu = 1; bs = 1; cyc(12); bu = 0; bs = 0; cyc(15);
      chk("up_stop_together_idle", int'(ms0), 0);
      bu = 1; bd = 1; cyc(12); bu = 0; bd = 0; cyc(15);
      chk("up_down_together_up", int'(ms0), 1);
      press_up(12);
      chk("repeat_up_unchanged", int'({a1, a0}), 2);
      // auto-stop at limits
      cin = 4'd14; cyc(3);
      chk("auto_14_still_up", int'(ms1), 1);
      cin = 4'd15; cyc(1);
      chk("auto_15_pause", int'(ms1), 3);
      chk("noauto_15_up", int'(ms0), 1);
      press_dn(12);
      chk("auto_down_at_15", int'(ms1), 2);
      cin = 4'd0; cyc(1);
      chk("auto_0_pause", int'(ms1), 3);
      chk("noauto_0_down", int'(ms0), 2);
      cin = 4'd5;
      // reset mid-operation with button held
      bu = 1; cyc(12);
      chk("pre_reset_up", int'(ms0), 1);
      rst = 1; cyc(1);
      chk("reset_immediate_idle", int'({a1, a0}), 0);
      rst = 0;
      cyc(10);
      chk("post_reset_edge10_idle", int'(ms0), 0);
      cyc(1);
      chk("post_reset_edge11_up", int'(ms0), 1);
      bu = 0; cyc(15);
      // random phase
      btn = 0;
      for (int i = 0; i < 4000; i++) begin
         for (int b = 0; b < 3; b++)
            if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
         {bs, bd, bu} = btn;
         if ($urandom_range(0, 3) == 0)
            cin = ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(0, 1)) * 15) : 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 599) == 0);
         cyc(1);
      end
      rst = 0; {bs, bd, bu} = 3'b000;
      cyc(20);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
